aes128_wb_ctrl: RTL and testbench
=================================

AES128_WB_CTRL -- requirements
Module: aes128_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; bits [31:8] are decoded.
REQ-002 SHALL have parameter LATENCY, default 21, clock cycles from operand launch to valid aes128 out; legal range 1..255.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-007 SHALL have ports wbs_adr_i  in  32, wbs_dat_i  in  32, wbs_sel_i  in  4  address, write data and byte enables.
REQ-008 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  acknowledge and read data.
REQ-009 SHALL have ports aes_key  out  128, aes_state  out  128, aes_out  in  128  key, plaintext and ciphertext of the aes128 core.
REQ-010 SHALL have port irq  out  1  done interrupt, connected to user_irq[0] at wrapper level.

Function
REQ-011 Register map, byte offsets: 0x00-0x0C KEY0-3 (rw); 0x10-0x1C DATA0-3 (rw); 0x20 CTRL (bit0 START wo, reads 0; bit1 IRQ_EN rw); 0x24 STATUS (bit0 BUSY ro; bit1 DONE, write-1-to-clear); 0x28-0x34 OUT0-3 (ro).
REQ-012 Word n of each bank SHALL map to bits [32n+31:32n]: KEY0 = aes_key[31:0], KEY3 = aes_key[127:96]; DATA and OUT follow the same order.
REQ-013 A request SHALL be accepted on any edge with cyc&stb&!ack and a decoded base address; wbs_ack_o SHALL be high for exactly one cycle, on the cycle after acceptance.
REQ-014 Writes SHALL take effect on the acceptance edge and honour wbs_sel_i per byte; read data SHALL be registered and valid while wbs_ack_o is high.
REQ-015 Unmapped offsets SHALL be acknowledged; reads return 32'h0 and writes are ignored; a non-decoded base address SHALL get no ack.
REQ-016 The FSM SHALL have three states. IDLE: START -> RUN with counter loaded to LATENCY-1. RUN: counter decrements each cycle; at counter==0 -> DONE, capturing aes_out into OUT0-3 and setting DONE. DONE: START -> RUN.
REQ-017 The OUT capture and DONE=1 SHALL occur exactly LATENCY edges after the START acceptance edge.
REQ-018 aes_key and aes_state SHALL be driven continuously from KEY0-3 and DATA0-3.
REQ-019 While BUSY, writes to KEY and DATA SHALL be acknowledged but discarded, and START SHALL be ignored. BUSY = (state == RUN).
REQ-020 A START accepted in DONE SHALL clear DONE on the same edge. START with a DONE write-1 in the same write SHALL start the operation and leave DONE=0.
REQ-021 A DONE write-1 SHALL clear DONE; DONE set and clear on the same edge SHALL resolve to set.
REQ-022 irq SHALL be a registered output equal to DONE & IRQ_EN.
REQ-023 OUT0-3 SHALL hold their value until the next capture.

Reset
REQ-024 On rst_n low, asynchronously: FSM = IDLE, counter = 0, all KEY, DATA and OUT registers = 0, IRQ_EN = 0, DONE = 0, wbs_ack_o = 0, wbs_dat_o = 0, irq = 0.
REQ-025 Reset during RUN SHALL abort the operation with no capture; the first START after reset release SHALL behave per REQ-016.

Structure
REQ-026 Package aes128_ctrl_pkg SHALL hold the register offsets, CTRL/STATUS bit indices, the FSM state enum and the LATENCY default.
REQ-027 The block SHALL contain no sub-module; the aes128 core is instantiated beside it in user_project_wrapper.

Verification
REQ-028 Write KEY3..0 = 00010203/04050607/08090a0b/0c0d0e0f and DATA3..0 = 00112233/44556677/8899aabb/ccddeeff, then START -> DONE after exactly LATENCY edges; OUT3..0 = 69c4e0d8/6a7b0430/d8cdb780/70b4c55a.
REQ-029 During RUN, write KEY0 = ffffffff and issue START -> both acknowledged, aes_key unchanged, BUSY stays 1, capture timing unchanged.
REQ-030 Write KEY1 = 11223344 with sel = 4'b0101 over a previous value of 0 -> KEY1 reads 00220044.
REQ-031 IRQ_EN = 1, complete an operation -> irq rises one cycle after DONE; write STATUS = 2 -> DONE = 0 and irq = 0; START with DONE = 1 -> DONE clears on the acceptance edge.
REQ-032 Assert rst_n low at RUN counter = 5 -> all outputs 0 immediately, no capture; after release, a fresh START completes correctly.
REQ-033 Read offset 0x40 -> ack after 1 cycle, data 0; access to address 0x4000_0000 -> no ack.

Source files
------------

// File: rtl/aes128_ctrl_pkg.sv
// Shared definitions for the AES-128 Wishbone control block:
// register offsets, CTRL/STATUS bit positions, FSM states and a byte-merge helper.
package aes128_ctrl_pkg;

    localparam int unsigned LATENCY_DEFAULT = 21;

    localparam logic [7:0] OFF_KEY0   = 8'h00;
    localparam logic [7:0] OFF_DATA0  = 8'h10;
    localparam logic [7:0] OFF_CTRL   = 8'h20;
    localparam logic [7:0] OFF_STATUS = 8'h24;
    localparam logic [7:0] OFF_OUT0   = 8'h28;
    localparam logic [7:0] OFF_OUT3   = 8'h34;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/aes128_wb_ctrl.sv
// Wishbone slave that holds key/plaintext for an external AES-128 core,
// times the core's fixed latency and captures its ciphertext.
module aes128_wb_ctrl
    import aes128_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned LATENCY   = LATENCY_DEFAULT
) (
    input  logic         wb_clk_i,
    input  logic         rst_n,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [3:0]   wbs_sel_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] aes_key,
    output logic [127:0] aes_state,
    input  logic [127:0] aes_out,
    output logic         irq
);

    logic [31:0] key_q  [4];
    logic [31:0] data_q [4];
    logic [31:0] out_q  [4];
    logic        irq_en;
    logic        done;
    state_e      state;
    logic [7:0]  count;

    logic        accept, wr, busy, start_go, done_w1c;
    logic [7:0]  off;
    logic [1:0]  idx, out_idx;
    logic        key_hit, data_hit, out_hit;
    logic [31:0] rd_data;
    logic        unused_adr;

    assign accept = wbs_cyc_i && wbs_stb_i && !wbs_ack_o
                 && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr         = accept && wbs_we_i;
    assign off        = {wbs_adr_i[7:2], 2'b00};
    assign unused_adr = ^wbs_adr_i[1:0];
    assign idx        = off[3:2];
    assign key_hit    = (off[7:4] == 4'h0);
    assign data_hit   = (off[7:4] == 4'h1);
    assign out_hit    = (off >= OFF_OUT0) && (off <= OFF_OUT3);
    // OUT0 sits at word index 2 of its 16-byte line; 2-bit wrap maps 0x28..0x34 to 0..3.
    assign out_idx    = off[3:2] - OFF_OUT0[3:2];

    assign busy     = (state == ST_RUN);
    assign start_go = wr && !busy && (off == OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
    assign done_w1c = wr && (off == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[STATUS_DONE];

    assign aes_key   = {key_q[3],  key_q[2],  key_q[1],  key_q[0]};
    assign aes_state = {data_q[3], data_q[2], data_q[1], data_q[0]};

    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch is inferred.
        rd_data = '0;
        if (key_hit)
            rd_data = key_q[idx];
        else if (data_hit)
            rd_data = data_q[idx];
        else if (out_hit)
            rd_data = out_q[out_idx];
        else if (off == OFF_CTRL)
            rd_data[CTRL_IRQ_EN] = irq_en;
        else if (off == OFF_STATUS) begin
            rd_data[STATUS_BUSY] = busy;
            rd_data[STATUS_DONE] = done;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            irq_en    <= 1'b0;
            // NOTE: the register banks are architecturally visible, so they are reset, not left as RAM.
            for (int i = 0; i < 4; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            wbs_ack_o <= accept;
            if (accept)
                wbs_dat_o <= rd_data;
            if (wr && !busy && key_hit)
                key_q[idx] <= merge_bytes(key_q[idx], wbs_dat_i, wbs_sel_i);
            if (wr && !busy && data_hit)
                data_q[idx] <= merge_bytes(data_q[idx], wbs_dat_i, wbs_sel_i);
            if (wr && (off == OFF_CTRL) && wbs_sel_i[0])
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
            irq   <= 1'b0;
            for (int i = 0; i < 4; i++)
                out_q[i] <= '0;
        end else begin
            irq <= done && irq_en;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        state <= ST_RUN;
                        count <= 8'(LATENCY - 1);
                    end
                end
                ST_RUN: begin
                    if (count == '0) begin
                        state <= ST_DONE;
                        for (int i = 0; i < 4; i++)
                            out_q[i] <= aes_out[32*i +: 32];
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Capture wins over a same-edge clear.
            if (busy && (count == '0))
                done <= 1'b1;
            else if (start_go || done_w1c)
                done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes128_wb_ctrl.sv
// Self-checking bench for aes128_wb_ctrl: a transaction-level model of the register
// map and operation timeline, with the bench standing in for the AES core.
`timescale 1ns/1ps
module tb_aes128_wb_ctrl;

    localparam int LAT = 21;
    localparam logic [31:0]  BASE     = 32'h3000_0000;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk, rst_n;
    logic         cyc_i, stb_i, we_i;
    logic [31:0]  adr_i, dat_i;
    logic [3:0]   sel_i;
    logic         ack_o;
    logic [31:0]  dat_o;
    logic [127:0] aes_key, aes_state, aes_out;
    logic         irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    bit tag_mode = 0;

    aes128_wb_ctrl #(.BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .wbs_cyc_i(cyc_i),
        .wbs_stb_i(stb_i),
        .wbs_we_i (we_i),
        .wbs_adr_i(adr_i),
        .wbs_dat_i(dat_i),
        .wbs_sel_i(sel_i),
        .wbs_ack_o(ack_o),
        .wbs_dat_o(dat_o),
        .aes_key  (aes_key),
        .aes_state(aes_state),
        .aes_out  (aes_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: in tag mode its output encodes the current cycle, exposing capture timing.
    function automatic logic [127:0] tag_val(input int c);
        return {32'(c + 3), 32'(c + 2), 32'(c + 1), 32'(c)};
    endfunction
    assign aes_out = tag_mode ? tag_val(cyc) : FIPS_CT;

    // ---------------- reference model ----------------
    logic [31:0]  m_key [4];
    logic [31:0]  m_data[4];
    logic [31:0]  m_out [4];
    logic         m_done, m_irq_en, m_running;
    int           m_run_a;
    logic [127:0] m_pend;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = '0; m_data[i] = '0; m_out[i] = '0;
        end
        m_done = 0; m_irq_en = 0; m_running = 0; m_run_a = 0; m_pend = '0;
    endtask

    // Apply a completion whose capture edge is at or before edge 'upto'.
    task automatic model_advance(input int upto);
        if (m_running && (m_run_a + LAT <= upto)) begin
            m_running = 0;
            m_done    = 1;
            for (int i = 0; i < 4; i++) m_out[i] = m_pend[32*i +: 32];
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    task automatic model_access(input bit we, input logic [7:0] off, input logic [31:0] dat,
                                input logic [3:0] sel, input int acc, output logic [31:0] e);
        bit busy;
        model_advance(acc - 1);
        busy = m_running;
        e = 32'h0;
        if (off < 8'h10)                     e = m_key[off[3:2]];
        else if (off < 8'h20)                e = m_data[off[3:2]];
        else if (off == 8'h20)               e = {30'h0, m_irq_en, 1'b0};
        else if (off == 8'h24)               e = {30'h0, m_done, busy};
        else if (off >= 8'h28 && off <= 8'h34) e = m_out[int'((off - 8'h28) >> 2)];
        if (we) begin
            if (off < 8'h10 && !busy)      m_key[off[3:2]]  = bmerge(m_key[off[3:2]], dat, sel);
            else if (off >= 8'h10 && off < 8'h20 && !busy)
                                           m_data[off[3:2]] = bmerge(m_data[off[3:2]], dat, sel);
            else if (off == 8'h20 && sel[0]) begin
                m_irq_en = dat[1];
                if (dat[0] && !busy) begin
                    m_running = 1; m_run_a = acc; m_done = 0;
                    m_pend = tag_mode ? tag_val(acc + LAT - 1) : FIPS_CT;
                end
            end else if (off == 8'h24 && sel[0] && dat[1])
                m_done = 0;
        end
        model_advance(acc);
    endtask

    // ---------------- bus helpers ----------------
    task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output bit acked);
        acked = 0; rdata = '0;
        @(negedge clk);
        cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack_o) begin
                acked = 1; rdata = dat_o; last_acc = cyc;
            end
        end
        @(negedge clk);
        cyc_i = 0; stb_i = 0; we_i = 0;
    endtask

    task automatic access(input bit we, input logic [7:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] r, output logic [31:0] e,
                          output bit ak);
        wb(we, BASE | {24'h0, off}, dat, sel, r, ak);
        e = 32'h0;
        if (ak) model_access(we, off, dat, sel, last_acc, e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_fips();
        logic [31:0] r, e; bit ak;
        for (int i = 0; i < 4; i++) begin
            access(1, 8'(4*i),        FIPS_KEY[32*i +: 32], 4'hF, r, e, ak);
            access(1, 8'(8'h10 + 4*i), FIPS_PT[32*i +: 32],  4'hF, r, e, ak);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; dat_i = '0; sel_i = '0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (ack_o !== 1'b0)    begin failures++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        checks++; if (dat_o !== 32'h0)   begin failures++; $display("FAIL reset_dat: got %h want 0", dat_o); end
        checks++; if (irq !== 1'b0)      begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (aes_key !== '0)    begin failures++; $display("FAIL reset_key: got %h want 0", aes_key); end
        checks++; if (aes_state !== '0)  begin failures++; $display("FAIL reset_state: got %h want 0", aes_state); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_fips();
        logic [31:0] r, e; bit ak; int a;
        tag_mode = 0;
        load_fips();
        checks++; if (aes_key !== FIPS_KEY)  begin failures++; $display("FAIL fips_key: got %h want %h", aes_key, FIPS_KEY); end
        checks++; if (aes_state !== FIPS_PT) begin failures++; $display("FAIL fips_state: got %h want %h", aes_state, FIPS_PT); end
        access(1, 8'h20, 32'h1, 4'hF, r, e, ak);
        a = last_acc;
        wait_cyc(a + LAT - 1);
        access(0, 8'h24, 0, 4'hF, r, e, ak);   // accepted on the capture edge: still busy
        checks++; if (r !== 32'h1 || r !== e) begin failures++; $display("FAIL fips_busy_at_capture: got %h want %h", r, e); end
        access(0, 8'h24, 0, 4'hF, r, e, ak);
        checks++; if (r !== 32'h2 || r !== e) begin failures++; $display("FAIL fips_done: got %h want %h", r, e); end
        for (int i = 0; i < 4; i++) begin
            access(0, 8'(8'h28 + 4*i), 0, 4'hF, r, e, ak);
            checks++;
            if (r !== FIPS_CT[32*i +: 32] || r !== e) begin
                failures++; $display("FAIL fips_out%0d: got %h want %h", i, r, FIPS_CT[32*i +: 32]);
            end
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] r, e; bit ak; int a; logic [127:0] k0;
        tag_mode = 1;
        access(1, 8'h20, 32'h1, 4'hF, r, e, ak);
        a = last_acc; k0 = aes_key;
        access(1, 8'h00, 32'hffff_ffff, 4'hF, r, e, ak);
        checks++; if (!ak) begin failures++; $display("FAIL busy_key_ack: got 0 want 1"); end
        checks++; if (aes_key !== k0) begin failures++; $display("FAIL busy_key_kept: got %h want %h", aes_key, k0); end
        access(1, 8'h20, 32'h1, 4'hF, r, e, ak);
        checks++; if (!ak) begin failures++; $display("FAIL busy_start_ack: got 0 want 1"); end
        access(0, 8'h24, 0, 4'hF, r, e, ak);
        checks++; if (r !== 32'h1 || r !== e) begin failures++; $display("FAIL busy_status: got %h want %h", r, e); end
        wait_cyc(a + LAT + 1);
        for (int i = 0; i < 4; i++) begin
            access(0, 8'(8'h28 + 4*i), 0, 4'hF, r, e, ak);
            checks++;
            if (r !== tag_val(a + LAT - 1)[32*i +: 32] || r !== e) begin
                failures++; $display("FAIL busy_capture_time%0d: got %h want %h", i, r, e);
            end
        end
    endtask

    task automatic test_sel();
        logic [31:0] r, e; bit ak;
        access(1, 8'h04, 32'h0, 4'hF, r, e, ak);
        access(1, 8'h04, 32'h1122_3344, 4'b0101, r, e, ak);
        access(0, 8'h04, 0, 4'hF, r, e, ak);
        checks++; if (r !== 32'h0022_0044 || r !== e) begin failures++; $display("FAIL sel_key1: got %h want 00220044", r); end
    endtask

    task automatic test_irq();
        logic [31:0] r, e; bit ak; int a, first;
        access(1, 8'h20, 32'h2, 4'hF, r, e, ak);
        access(1, 8'h20, 32'h3, 4'hF, r, e, ak);
        a = last_acc; first = -1;
        for (int k = 0; k < LAT + 8; k++) begin
            @(posedge clk); #1;
            if (irq && first < 0) first = cyc;
        end
        checks++; if (first != a + LAT + 1) begin failures++; $display("FAIL irq_rise: got edge %0d want %0d", first - a, LAT + 1); end
        access(1, 8'h24, 32'h2, 4'hF, r, e, ak);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", irq); end
        access(0, 8'h24, 0, 4'hF, r, e, ak);
        checks++; if (r !== 32'h0 || r !== e) begin failures++; $display("FAIL w1c_status: got %h want %h", r, e); end
        access(1, 8'h20, 32'h3, 4'hF, r, e, ak);
        wait_cyc(last_acc + LAT + 1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_second: got %b want 1", irq); end
        access(1, 8'h20, 32'h3, 4'hF, r, e, ak);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold_at_start: got %b want 1", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_start: got %b want 0", irq); end
        access(0, 8'h24, 0, 4'hF, r, e, ak);
        checks++; if (r !== 32'h1 || r !== e) begin failures++; $display("FAIL start_clears_done: got %h want %h", r, e); end
        wait_cyc(m_run_a + LAT + 1);
    endtask

    task automatic test_unmapped();
        logic [31:0] r, e; bit ak;
        @(negedge clk);
        cyc_i = 1; stb_i = 1; we_i = 0; adr_i = BASE | 32'h40; sel_i = 4'hF;
        @(posedge clk); #1;
        checks++; if (ack_o !== 1'b1)  begin failures++; $display("FAIL unmapped_ack: got %b want 1", ack_o); end
        checks++; if (dat_o !== 32'h0) begin failures++; $display("FAIL unmapped_data: got %h want 0", dat_o); end
        @(posedge clk); #1;
        checks++; if (ack_o !== 1'b0)  begin failures++; $display("FAIL ack_one_cycle: got %b want 0", ack_o); end
        @(negedge clk);
        cyc_i = 0; stb_i = 0;
        access(1, 8'h40, 32'hdead_beef, 4'hF, r, e, ak);
        access(0, 8'h40, 0, 4'hF, r, e, ak);
        checks++; if (!ak || r !== 32'h0) begin failures++; $display("FAIL unmapped_write: got %h want 0", r); end
        wb(0, 32'h4000_0000, 0, 4'hF, r, ak);
        checks++; if (ak) begin failures++; $display("FAIL foreign_read_ack: got 1 want 0"); end
        wb(1, 32'h4000_0010, 32'h1234_5678, 4'hF, r, ak);
        checks++; if (ak || aes_state !== {m_data[3], m_data[2], m_data[1], m_data[0]}) begin
            failures++; $display("FAIL foreign_write: ack %b state %h", ak, aes_state);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, e, d; bit ak, we; logic [7:0] off; logic [3:0] sel;
        tag_mode = 1;
        for (int n = 0; n < 60; n++) begin
            off = 8'($urandom_range(0, 16) * 4);
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            sel = 4'($urandom);
            access(we, off, d, sel, r, e, ak);
            if (!we) begin
                checks++;
                if (!ak || r !== e) begin failures++; $display("FAIL rand_read off=%h: got %h want %h", off, r, e); end
            end
            checks++;
            if (aes_key !== {m_key[3], m_key[2], m_key[1], m_key[0]} ||
                aes_state !== {m_data[3], m_data[2], m_data[1], m_data[0]}) begin
                failures++; $display("FAIL rand_drive n=%0d: key %h state %h", n, aes_key, aes_state);
            end
        end
        if (m_running) wait_cyc(m_run_a + LAT + 1);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r, e; bit ak; int a;
        tag_mode = 0;
        load_fips();
        access(1, 8'h20, 32'h3, 4'hF, r, e, ak);
        a = last_acc;
        wait_cyc(a + LAT - 6);                 // counter now reads 5
        @(negedge clk) rst_n = 0;
        #1;
        checks++;
        if (ack_o !== 0 || dat_o !== 0 || irq !== 0 || aes_key !== 0 || aes_state !== 0) begin
            failures++; $display("FAIL midrun_reset_outputs: key %h state %h irq %b", aes_key, aes_state, irq);
        end
        model_reset();
        repeat (LAT) @(posedge clk);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            access(0, 8'(8'h28 + 4*i), 0, 4'hF, r, e, ak);
            checks++; if (r !== 32'h0 || r !== e) begin failures++; $display("FAIL midrun_no_capture%0d: got %h want 0", i, r); end
        end
        access(0, 8'h24, 0, 4'hF, r, e, ak);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL midrun_status: got %h want 0", r); end
        load_fips();
        access(1, 8'h20, 32'h1, 4'hF, r, e, ak);
        wait_cyc(last_acc + LAT + 1);
        for (int i = 0; i < 4; i++) begin
            access(0, 8'(8'h28 + 4*i), 0, 4'hF, r, e, ak);
            checks++;
            if (r !== FIPS_CT[32*i +: 32] || r !== e) begin
                failures++; $display("FAIL post_reset_out%0d: got %h want %h", i, r, FIPS_CT[32*i +: 32]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips();
        test_busy_writes();
        test_sel();
        test_irq();
        test_unmapped();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
